// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single request port of the cached data memory between the
//   MIPSCORE data port (requester C, stall-based) and a loader/DMA engine
//   (requester L, req/ack handshake). C has fixed priority; L is guaranteed
//   the port after being passed over MAX_WAIT times. A transaction owns the
//   memory port until the memory drops its stall.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_c_ren/i_c_wen/
//   i_c_addr/i_c_data       CPU request (read enable, byte write enables)
//   o_c_data, o_c_stall     CPU read data (from memory) and stall
//   i_l_req/i_l_wen/
//   i_l_addr/i_l_data       loader request, held until o_l_ack; wen=0 is a read
//   o_l_ack, o_l_data       registered one-cycle completion pulse and read data
//   o_m_ren/o_m_wen/
//   o_m_addr/o_m_data       request forwarded to the cached memory
//   i_m_data, i_m_stall     response from the cached memory
module dmem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_c_ren,
    input  logic [3:0]        i_c_wen,
    input  logic [ADDR_W-1:0] i_c_addr,
    input  logic [31:0]       i_c_data,
    output logic [31:0]       o_c_data,
    output logic              o_c_stall,
    input  logic              i_l_req,
    input  logic [3:0]        i_l_wen,
    input  logic [ADDR_W-1:0] i_l_addr,
    input  logic [31:0]       i_l_data,
    output logic              o_l_ack,
    output logic [31:0]       o_l_data,
    output logic              o_m_ren,
    output logic [3:0]        o_m_wen,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic [31:0]       o_m_data,
    input  logic [31:0]       i_m_data,
    input  logic              i_m_stall
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_C = 2'd1,
        ST_BUSY_L = 2'd2
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t      state_r;
    logic [7:0]  wait_r;
    logic        l_ack_r;
    logic [31:0] l_data_r;

    logic c_act_s;
    logic l_act_s;
    logic own_c_s;
    logic own_l_s;
    logic l_done_s;

    // Request qualification; the loader is masked during its ack cycle so a
    // still-held request is not issued a second time.
    always_comb begin
        c_act_s = i_c_ren | (|i_c_wen);
        l_act_s = i_l_req & ~l_ack_r;
    end

    // Owner selection: arbitrate in IDLE, hold the owner while busy.
    always_comb begin
        own_c_s = 1'b0;
        own_l_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (l_act_s && (!c_act_s || (wait_r == MAX_WAIT_C))) begin
                    own_l_s = 1'b1;
                end else if (c_act_s) begin
                    own_c_s = 1'b1;
                end else begin
                    own_c_s = 1'b0;
                    own_l_s = 1'b0;
                end
            end
            ST_BUSY_C: own_c_s = 1'b1;
            ST_BUSY_L: own_l_s = 1'b1;
            default: begin
                own_c_s = 1'b0;
                own_l_s = 1'b0;
            end
        endcase
    end

    // Loader completes on any owned cycle in which the memory is not stalling.
    always_comb begin
        l_done_s = own_l_s & ~i_m_stall;
    end

    // Memory port mux; the port is quiet while reset is held.
    always_comb begin
        o_m_ren  = 1'b0;
        o_m_wen  = 4'b0000;
        o_m_addr = '0;
        o_m_data = 32'h0000_0000;
        if (i_rst) begin
            o_m_ren  = 1'b0;
        end else if (own_c_s) begin
            o_m_ren  = i_c_ren;
            o_m_wen  = i_c_wen;
            o_m_addr = i_c_addr;
            o_m_data = i_c_data;
        end else if (own_l_s) begin
            o_m_ren  = (i_l_wen == 4'b0000);
            o_m_wen  = i_l_wen;
            o_m_addr = i_l_addr;
            o_m_data = i_l_data;
        end else begin
            o_m_ren  = 1'b0;
        end
    end

    // CPU side: stall whenever C wants the port but does not complete now.
    always_comb begin
        o_c_data  = i_m_data;
        o_c_stall = ~i_rst & c_act_s & (~own_c_s | i_m_stall);
        o_l_ack   = l_ack_r;
        o_l_data  = l_data_r;
    end

    // FSM, starvation counter and registered loader response.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= ST_IDLE;
            wait_r   <= 8'd0;
            l_ack_r  <= 1'b0;
            l_data_r <= 32'h0000_0000;
        end else begin
            l_ack_r <= l_done_s;
            if (l_done_s) begin
                l_data_r <= i_m_data;
            end

            // L being served resets its debt; C beating a waiting L adds to it.
            if (own_l_s) begin
                wait_r <= 8'd0;
            end else if ((state_r == ST_IDLE) && l_act_s && own_c_s && (wait_r < MAX_WAIT_C)) begin
                wait_r <= wait_r + 8'd1;
            end

            case (state_r)
                ST_IDLE: begin
                    if (own_l_s && i_m_stall) begin
                        state_r <= ST_BUSY_L;
                    end else if (own_c_s && i_m_stall) begin
                        state_r <= ST_BUSY_C;
                    end
                end
                ST_BUSY_C: begin
                    if (!i_m_stall) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY_L: begin
                    if (!i_m_stall) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized self-checking bench for dmem_port_arbiter. A transaction-level
// reference model (current owner, pass-over count, pending ack) predicts every
// output each cycle; stimulus phases stress mixed traffic, loader starvation
// and mid-transaction resets.
module tb_dmem_port_arbiter;

    localparam int ADDR_W   = 32;
    localparam int MAX_WAIT = 8;
    localparam int N_CYC    = 3000;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_c_ren;
    logic [3:0]        i_c_wen;
    logic [ADDR_W-1:0] i_c_addr;
    logic [31:0]       i_c_data;
    logic [31:0]       o_c_data;
    logic              o_c_stall;
    logic              i_l_req;
    logic [3:0]        i_l_wen;
    logic [ADDR_W-1:0] i_l_addr;
    logic [31:0]       i_l_data;
    logic              o_l_ack;
    logic [31:0]       o_l_data;
    logic              o_m_ren;
    logic [3:0]        o_m_wen;
    logic [ADDR_W-1:0] o_m_addr;
    logic [31:0]       o_m_data;
    logic [31:0]       i_m_data;
    logic              i_m_stall;

    always #5 i_clk = ~i_clk;

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_c_ren(i_c_ren), .i_c_wen(i_c_wen), .i_c_addr(i_c_addr), .i_c_data(i_c_data),
        .o_c_data(o_c_data), .o_c_stall(o_c_stall),
        .i_l_req(i_l_req), .i_l_wen(i_l_wen), .i_l_addr(i_l_addr), .i_l_data(i_l_data),
        .o_l_ack(o_l_ack), .o_l_data(o_l_data),
        .o_m_ren(o_m_ren), .o_m_wen(o_m_wen), .o_m_addr(o_m_addr), .o_m_data(o_m_data),
        .i_m_data(i_m_data), .i_m_stall(i_m_stall)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: who holds the port (0 none, 1 CPU, 2 loader), how many
    // times L has been passed over, and the pending loader response.
    int          mdl_lock;
    int          mdl_wait;
    bit          mdl_ack;
    logic [31:0] mdl_ldata;
    bit          after_rst;
    bit          cpu_hold;
    int          l_served;
    int          starve_seen;

    initial begin
        int          p_cpu, p_ldr, p_stall, p_rst;
        int          owner;
        bit          c_act, l_act, exp_ren, exp_stall;
        logic [3:0]  exp_wen;
        logic [31:0] exp_addr, exp_data, tmp;

        mdl_lock = 0; mdl_wait = 0; mdl_ack = 1'b0; mdl_ldata = 32'h0;
        after_rst = 1'b0; cpu_hold = 1'b0; l_served = 0; starve_seen = 0;
        i_rst = 1'b1; i_c_ren = 1'b0; i_c_wen = 4'h0; i_c_addr = 32'h0; i_c_data = 32'h0;
        i_l_req = 1'b0; i_l_wen = 4'h0; i_l_addr = 32'h0; i_l_data = 32'h0;
        i_m_data = 32'h0; i_m_stall = 1'b0;
        #1;

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            // Phase knobs: mixed traffic, then CPU saturating the port, then
            // mixed traffic with occasional resets.
            if (cyc < 1000) begin
                p_cpu = 50; p_ldr = 40; p_stall = 35; p_rst = 0;
            end else if (cyc < 2000) begin
                p_cpu = 100; p_ldr = 90; p_stall = 10; p_rst = 0;
            end else begin
                p_cpu = 60; p_ldr = 50; p_stall = 40; p_rst = 3;
            end

            // Loader: keeps its request until the ack is visible.
            if (mdl_ack || !i_l_req) begin
                if ($urandom_range(99) < p_ldr) begin
                    i_l_req = 1'b1;
                    i_l_wen = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
                    tmp = $urandom; tmp[1:0] = 2'b00; i_l_addr = tmp;
                    i_l_data = $urandom;
                end else begin
                    i_l_req = 1'b0;
                    i_l_wen = 4'h0;
                end
            end
            // CPU: holds its access while stalled, like the core.
            if (!cpu_hold) begin
                if ($urandom_range(99) < p_cpu) begin
                    if ($urandom_range(1) == 0) begin
                        i_c_ren = 1'b1; i_c_wen = 4'h0;
                    end else begin
                        i_c_ren = 1'b0; i_c_wen = 4'($urandom_range(15, 1));
                    end
                    tmp = $urandom; tmp[1:0] = 2'b00; i_c_addr = tmp;
                    i_c_data = $urandom;
                end else begin
                    i_c_ren = 1'b0; i_c_wen = 4'h0;
                end
            end
            i_m_stall = ($urandom_range(99) < p_stall);
            i_m_data  = $urandom;
            i_rst     = (cyc < 2) || ($urandom_range(99) < p_rst);

            #4;
            // Prediction for this cycle.
            c_act = i_c_ren || (i_c_wen != 4'h0);
            l_act = i_l_req && !mdl_ack;
            owner = mdl_lock;
            if (owner == 0) begin
                if (l_act && (!c_act || mdl_wait == MAX_WAIT)) owner = 2;
                else if (c_act) owner = 1;
            end
            exp_ren = 1'b0; exp_wen = 4'h0; exp_addr = 32'h0; exp_data = 32'h0;
            if (!i_rst && owner == 1) begin
                exp_ren = i_c_ren; exp_wen = i_c_wen; exp_addr = i_c_addr; exp_data = i_c_data;
            end else if (!i_rst && owner == 2) begin
                exp_ren = (i_l_wen == 4'h0); exp_wen = i_l_wen; exp_addr = i_l_addr; exp_data = i_l_data;
            end
            exp_stall = !i_rst && c_act && (owner != 1 || i_m_stall);

            check_eq("m_ren",   o_m_ren,   exp_ren);
            check_eq("m_wen",   o_m_wen,   exp_wen);
            check_eq("m_addr",  o_m_addr,  exp_addr);
            check_eq("m_data",  o_m_data,  exp_data);
            check_eq("c_stall", o_c_stall, exp_stall);
            check_eq("c_data",  o_c_data,  i_m_data);
            check_eq("l_ack",   o_l_ack,   mdl_ack);
            if (mdl_ack || after_rst) check_eq("l_data", o_l_data, mdl_ldata);

            // Advance the model across the clock edge.
            if (i_rst) begin
                mdl_lock = 0; mdl_wait = 0; mdl_ack = 1'b0; mdl_ldata = 32'h0;
                after_rst = 1'b1;
            end else begin
                after_rst = 1'b0;
                if (owner == 2 && mdl_lock == 0 && c_act) starve_seen++;
                mdl_ack = (owner == 2) && !i_m_stall;
                if (mdl_ack) begin
                    mdl_ldata = i_m_data;
                    l_served++;
                end
                if (owner == 2) mdl_wait = 0;
                else if (mdl_lock == 0 && owner == 1 && l_act && mdl_wait < MAX_WAIT) mdl_wait++;
                mdl_lock = (owner != 0 && i_m_stall) ? owner : 0;
            end
            cpu_hold = exp_stall;

            @(posedge i_clk);
            #1;
        end

        // The run must have exercised loader completions and the starvation bound.
        check_eq("l_served_nonzero", (l_served > 0), 1'b1);
        check_eq("starvation_win_seen", (starve_seen > 0), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single request port of m_cached_memory between two requesters.
- Requester C is the MIPSCORE data port. It sees a stall, same as the core's D_* interface.
- Requester L is a loader/DMA engine using a req/ack handshake, e.g. for data-memory preload or dump.
- CPU has fixed priority, with a starvation bound for L. A transaction keeps ownership of the memory port until the memory drops stall.

Parameters:
- ADDR_W, 32, width of all addresses.
- MAX_WAIT, 8, number of cycles L may be denied before it wins the next arbitration (1..255).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_c_ren  in  1  CPU read request.
- i_c_wen  in  4  CPU byte write enables.
- i_c_addr  in  ADDR_W  CPU address, 4-byte aligned.
- i_c_data  in  32  CPU write data.
- o_c_data  out  32  CPU read data. Combinational from memory; valid in the cycle o_c_stall=0.
- o_c_stall  out  1  CPU stall.
- i_l_req  in  1  loader request. Held, with stable we/addr/data, until o_l_ack.
- i_l_wen  in  4  loader byte write enables. 0 means read.
- i_l_addr  in  ADDR_W  loader address.
- i_l_data  in  32  loader write data.
- o_l_ack  out  1  one-cycle completion pulse, registered.
- o_l_data  out  32  loader read data, registered. Valid while o_l_ack=1.
- o_m_ren  out  1  to cached memory i_dmem_ren.
- o_m_wen  out  4  to cached memory i_dmem_wen.
- o_m_addr  out  ADDR_W  to cached memory i_dmem_addr.
- o_m_data  out  32  to cached memory i_dmem_data.
- i_m_data  in  32  from cached memory o_dmem_data.
- i_m_stall  in  1  from cached memory o_dmem_stall.

Behaviour:
- Definitions:
  - c_act = i_c_ren | (|i_c_wen).
  - l_act = i_l_req & ~o_l_ack. The loader is masked for the ack cycle so one request cannot issue twice.
- Reset (synchronous, i_rst=1 at a clock edge):
  - state=IDLE, r_wait=0, o_l_ack=0, o_l_data=0.
  - While i_rst is high: o_m_ren=0, o_m_wen=0, o_c_stall=0. Reset mid-transaction abandons it; no ack is issued.
- FSM states: IDLE, BUSY_C, BUSY_L. The memory port carries the owner's request combinationally; a non-owned port drives zeros.
- IDLE, owner selection (same cycle):
  - L wins if l_act & (~c_act | r_wait==MAX_WAIT).
  - Else C wins if c_act.
  - Else there is no owner: all o_m_* are 0.
- IDLE, completion:
  - If the owner is selected and i_m_stall=0, the transaction completes this cycle and the state stays IDLE.
  - If i_m_stall=1, go to BUSY_C or BUSY_L.
- BUSY_x: keep forwarding owner x. Go to IDLE on the first cycle with i_m_stall=0; that cycle is the completion. No re-arbitration while busy.
- CPU side:
  - o_c_stall = c_act & (owner!=C | i_m_stall).
  - o_c_data = i_m_data.
  - When C has no request, o_c_stall=0 even if L holds the memory.
- Loader side: on the L completion cycle, the next edge sets o_l_ack=1 and o_l_data=i_m_data, both for exactly one cycle.
- Starvation counter r_wait:
  - Increments (saturating at MAX_WAIT) each IDLE cycle where l_act=1 and C wins.
  - Clears on any cycle in which L is the owner.
  - Unchanged otherwise.
- Simultaneous requests in IDLE with r_wait<MAX_WAIT: C wins and L waits silently.
- Back-to-back CPU accesses: a completion in IDLE allows a new selection next cycle, giving zero bubble.

Test Plan:
- C reads addr 0x40 with memory stall 0 -> same cycle o_m_addr=0x40, o_c_stall=0, o_c_data=i_m_data; state stays IDLE.
- L writes 0xDEADBEEF to 0x100 with wen=4'hF; memory stall high 3 cycles -> o_m_* held 3 cycles plus the completion cycle; o_l_ack pulses once, one cycle after stall falls; L masked during ack.
- C and L request together, stall 0, C requesting continuously, MAX_WAIT=8 -> C owns 8 cycles (r_wait 1..8); 9th cycle L is owner; o_c_stall=1 that cycle; r_wait=0 after.
- L owns in BUSY_L (stall high) when C issues a read -> o_c_stall=1 until L completes; C is selected the following IDLE cycle.
- L read of 0x200, memory returns 0x12345678 -> o_l_data=0x12345678 while o_l_ack=1.
- i_rst asserted during BUSY_C -> next cycle state=IDLE, o_m_ren=0, o_l_ack=0, r_wait=0; no ack ever emitted for the aborted transaction.
